// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ex_mem_pkg
// Description : Default EX->MEM widths and the default-width payload struct.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_pkg;

  localparam int c_inst_w   = 32;
  localparam int c_addr_w   = 32;
  localparam int c_data_w   = 32;
  localparam int c_reg_w    = 5;
  localparam int c_lsu_op_w = 4;

  typedef struct packed {
    logic [c_inst_w-1:0]   inst;
    logic [c_addr_w-1:0]   pc;
    logic [c_data_w-1:0]   ex_result;
    logic [c_reg_w-1:0]    rw_addr;
    logic                  rw_en;
    logic [c_data_w-1:0]   lsu_data;
    logic [c_lsu_op_w-1:0] lsu_op;
  } ex_mem_payload_t;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf
// Description : Payload-agnostic two-entry (main + skid) buffer with a
//               registered in_ready and a flush that empties both slots.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  logic                 r_main_valid, r_skid_valid, r_in_ready;
  logic [PAYLOAD_W-1:0] r_main_data, r_skid_data;
  logic                 w_main_valid, w_skid_valid;
  logic [PAYLOAD_W-1:0] w_main_data, w_skid_data;
  logic                 w_in_fire, w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_main_valid & out_ready;

  always_comb begin
    w_main_valid = r_main_valid;
    w_skid_valid = r_skid_valid;
    w_main_data  = r_main_data;
    w_skid_data  = r_skid_data;
    if (flush) begin
      w_main_valid = 1'b0;
      w_skid_valid = 1'b0;
    end else if (r_skid_valid) begin
      // in_ready is low whenever skid is full, so only the drain case exists
      if (w_out_fire) begin
        w_main_data  = r_skid_data;
        w_skid_valid = 1'b0;
      end
    end else if (!r_main_valid || w_out_fire) begin
      w_main_valid = w_in_fire;
      if (w_in_fire) w_main_data = in_data;
    end else if (w_in_fire) begin
      w_skid_data  = in_data;
      w_skid_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_main_data  <= '0;
      r_skid_data  <= '0;
    end else begin
      r_main_valid <= w_main_valid;
      r_skid_valid <= w_skid_valid;
      r_in_ready   <= !w_skid_valid;
      r_main_data  <= w_main_data;
      r_skid_data  <= w_skid_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;

endmodule
`default_nettype wire

// File: rtl/ex_mem_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_pipe_reg
// Description : EX->MEM pipeline register on a two-entry skid buffer.
//               EX_MEM_STALL_CNT_EN adds the stall_cnt backpressure counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_pipe_reg
  import ex_mem_pkg::*;
#(
  parameter int INST_W   = c_inst_w,
  parameter int ADDR_W   = c_addr_w,
  parameter int DATA_W   = c_data_w,
  parameter int REG_W    = c_reg_w,
  parameter int LSU_OP_W = c_lsu_op_w
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_W-1:0]   in_inst,
  input  logic [ADDR_W-1:0]   in_pc,
  input  logic [DATA_W-1:0]   in_ex_result,
  input  logic [REG_W-1:0]    in_rw_addr,
  input  logic                in_rw_en,
  input  logic [DATA_W-1:0]   in_lsu_data,
  input  logic [LSU_OP_W-1:0] in_lsu_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INST_W-1:0]   out_inst,
  output logic [ADDR_W-1:0]   out_pc,
  output logic [DATA_W-1:0]   out_ex_result,
  output logic [REG_W-1:0]    out_rw_addr,
  output logic                out_rw_en,
  output logic [DATA_W-1:0]   out_lsu_data,
  output logic [LSU_OP_W-1:0] out_lsu_op
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  // Same field order as ex_mem_payload_t, but sized by this instance's parameters
  typedef struct packed {
    logic [INST_W-1:0]   inst;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   ex_result;
    logic [REG_W-1:0]    rw_addr;
    logic                rw_en;
    logic [DATA_W-1:0]   lsu_data;
    logic [LSU_OP_W-1:0] lsu_op;
  } payload_t;

  localparam int c_payload_w = $bits(payload_t);

  payload_t w_in, w_out;
  logic     w_main_valid;

  assign w_in = '{inst: in_inst, pc: in_pc, ex_result: in_ex_result,
                  rw_addr: in_rw_addr, rw_en: in_rw_en,
                  lsu_data: in_lsu_data, lsu_op: in_lsu_op};

  pipe_skid_buf #(
    .PAYLOAD_W (c_payload_w)
  ) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in),
    .out_valid (w_main_valid),
    .out_ready (out_ready),
    .out_data  (w_out)
  );

  assign out_valid     = w_main_valid;
  assign out_inst      = w_out.inst;
  assign out_pc        = w_out.pc;
  assign out_ex_result = w_out.ex_result;
  assign out_rw_addr   = w_out.rw_addr;
  assign out_rw_en     = w_out.rw_en & w_main_valid;
  assign out_lsu_data  = w_out.lsu_data;
  assign out_lsu_op    = w_out.lsu_op;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating; survives flush so the count reflects the whole run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_main_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised, fully registered EX→MEM pipeline register carrying the execute-stage payload (inst, pc, ex_result, rw_addr, rw_en, lsu_data, lsu_op) with valid/ready handshakes on both sides. A two-entry skid buffer (main + skid) lets MEM apply backpressure without a combinational ready path into EX. A flush input discards in-flight entries on a redirect.

## Interface
Parameters:
- INST_W, default 32: instruction width.
- ADDR_W, default 32: pc width.
- DATA_W, default 32: ex_result and lsu_data width.
- REG_W, default 5: register address width.
- LSU_OP_W, default 4: LSU opcode width.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- flush  input  1  discard all held entries.
- in_valid  input  1  EX payload valid.
- in_ready  output  1  buffer can accept; registered.
- in_inst / in_pc / in_ex_result / in_rw_addr / in_rw_en / in_lsu_data / in_lsu_op  input  INST_W / ADDR_W / DATA_W / REG_W / 1 / DATA_W / LSU_OP_W  EX payload.
- out_valid  output  1  MEM payload valid.
- out_ready  input  1  MEM accepts.
- out_inst / out_pc / out_ex_result / out_rw_addr / out_rw_en / out_lsu_data / out_lsu_op  output  same widths  MEM payload.
- stall_cnt  output  32  backpressure cycle count (only with EX_MEM_STALL_CNT_EN).

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset: main_valid=0, skid_valid=0, in_ready=1, all payload registers 0, stall_cnt=0.
- out_valid = main_valid. out_rw_en = main rw_en & main_valid (never a write from an empty slot). Other out_* are the main payload registers directly.
- in_ready next = !skid_valid next.
- Per-cycle update (non-flush):
  - Main empty or out_fire, skid empty: in_fire loads main; otherwise main_valid clears if out_fire.
  - Main full, no out_fire, in_fire: payload loads skid, skid_valid=1, in_ready drops next cycle.
  - out_fire with skid full: main ← skid, skid_valid=0, in_ready returns to 1 next cycle. in_fire is impossible that cycle (in_ready=0).
- Flush: next cycle main_valid=0, skid_valid=0, in_ready=1. Flush beats a simultaneous in_fire (entry dropped) and a simultaneous out_fire (MEM still takes the current entry that cycle). Payload registers need not clear.
- Order preserved: FIFO, depth 2, no reordering or duplication.

## Timing
- Latency: in_fire at cycle N → out_valid with that payload at N+1 when main empty or freed.
- Throughput: 1 entry/cycle with out_ready held high; in_ready stays 1.
- Backpressure: out_ready low with main full → one more entry absorbed into skid; in_ready low from the next cycle until the first out_fire, then high the cycle after.
- Reset mid-transfer: all entries dropped immediately (async). First in_fire possible in the first clock after deassertion.
- No combinational path from out_ready to in_ready.

## Configuration
- EX_MEM_STALL_CNT_EN defined: stall_cnt port present. Increments each cycle with out_valid & !out_ready, saturates at 0xFFFF_FFFF, clears only on rst (not flush).
- Undefined: port and counter absent; otherwise identical behaviour.

## Structure
- Shared package ex_mem_pkg: default width constants (aligned with the global width definitions) and ex_mem_payload_t packed struct (inst, pc, ex_result, rw_addr, rw_en, lsu_data, lsu_op).
- Sub-module pipe_skid_buf: generic payload-agnostic two-entry skid buffer (parameter PAYLOAD_W, valid/ready, flush). ex_mem_pipe_reg packs/unpacks the struct around it and adds the rw_en qualification and stall counter.

## Test plan
- Reset: assert rst mid-stream with both entries full → out_valid=0, in_ready=1, out_rw_en=0 same cycle; stall_cnt=0.
- Streaming: out_ready=1, send pc=0x1c000000,0x1c000004,0x1c000008 on consecutive cycles → out_pc appears one cycle later each, in_ready never drops.
- Backpressure: out_ready=0, send pc=A then B → A held on out, B in skid, in_ready=0; raise out_ready → A, then B on next cycle, in_ready=1 one cycle after A leaves.
- Flush collision: skid full, flush=1 with in_valid=1 (pc=C) and out_ready=1 → current out consumed, next cycle out_valid=0, in_ready=1, C never appears.
- rw_en gating: in_rw_en=1 with in_valid=0 → out_rw_en stays 0.
- Counter (macro on): out_valid=1, out_ready=0 for 7 cycles → stall_cnt=7; preload 0xFFFF_FFFE, stall 3 cycles → 0xFFFF_FFFF.
